slc3_mem_arbiter: RTL and testbench

Two-port arbiter and SRAM strobe sequencer for the SLC-3 memory bus. It shares the single 16-bit SRAM between the processor and a debug/loader port. It runs every access as a fixed SETUP/ACCESS/DONE sequence with a parameterised wait count. It sits between the CPU, the debug loader and the top-level tristate/memory, and generates active-low CE/UB/LB/OE/WE.

---
 rtl/slc3_mem_pkg.sv | 20 ++
 rtl/slc3_mem_arbiter_wait_timer.sv | 27 ++
 rtl/slc3_mem_arbiter.sv | 166 ++++++++++++++++
 tb/tb_slc3_mem_arbiter.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/slc3_mem_pkg.sv
// Shared types and default widths for the SLC-3 SRAM arbiter slice.
package slc3_mem_pkg;

  localparam int ADDR_W_DEF = 20;
  localparam int DATA_W_DEF = 16;
  localparam int WAIT_CNT_W = $clog2(16);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    DONE
  } mem_state_t;

  typedef enum logic {
    PORT_CPU,
    PORT_DBG
  } port_sel_t;

endpackage

// File: rtl/slc3_mem_arbiter_wait_timer.sv
// Loadable down-counter that times the ACCESS phase of an SRAM transfer.
module mem_wait_timer
  import slc3_mem_pkg::*;
(
  input  logic                  clk,
  input  logic                  srst_n,
  input  logic                  load,
  input  logic [WAIT_CNT_W-1:0] load_val,
  input  logic                  dec,
  output logic                  zero
);

  logic [WAIT_CNT_W-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (!srst_n) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_val;
    end else if (dec && (count_reg != '0)) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  assign zero = (count_reg == '0);

endmodule

// File: rtl/slc3_mem_arbiter.sv
// Two-port SRAM arbiter and strobe sequencer (IDLE/SETUP/ACCESS/DONE).
// Define SLC3_MEM_ARB_DBG_EN to enable the debug/loader port and its anti-starvation logic.
module slc3_mem_arbiter
  import slc3_mem_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int WAIT_CYCLES = 2,
  parameter int STARVE_MAX  = 4
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ready,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_ready,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] A,
  output logic              CE,
  output logic              UB,
  output logic              LB,
  output logic              OE,
  output logic              WE,
  output logic [DATA_W-1:0] Data_out,
  output logic              drive_en,
  input  logic [DATA_W-1:0] Data_in
);

  mem_state_t        state_reg, state_next;
  port_sel_t         grant_reg, grant_next;
  logic [ADDR_W-1:0] addr_reg;
  logic              we_reg;
  logic [DATA_W-1:0] wdata_reg;
  logic [DATA_W-1:0] rdata_reg;
  logic              latch;
  logic              capture;
  logic              timer_load;
  logic              timer_dec;
  logic              timer_zero;
  logic              dbg_wins;

  mem_wait_timer u_wait_timer (
    .clk      (Clk),
    .srst_n   (Reset),
    .load     (timer_load),
    .load_val (WAIT_CNT_W'(WAIT_CYCLES - 1)),
    .dec      (timer_dec),
    .zero     (timer_zero)
  );

`ifdef SLC3_MEM_ARB_DBG_EN
  localparam int STARVE_W = $clog2(STARVE_MAX + 1);

  logic [STARVE_W-1:0] starve_reg;

  // Debug normally yields to the CPU, but is forced in once it has lost STARVE_MAX times in a row.
  assign dbg_wins = dbg_req && (!cpu_req || (starve_reg == STARVE_W'(STARVE_MAX)));

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      starve_reg <= '0;
    end else if (latch) begin
      if (grant_next == PORT_DBG) begin
        starve_reg <= '0;
      end else if (dbg_req && (starve_reg != STARVE_W'(STARVE_MAX))) begin
        starve_reg <= starve_reg + 1'b1;
      end
    end
  end

  assign dbg_ready = (state_reg == DONE) && (grant_reg == PORT_DBG);
`else
  logic unused_dbg_req;

  assign unused_dbg_req = dbg_req;
  assign dbg_wins       = 1'b0;
  assign dbg_ready      = 1'b0;
`endif

  always_comb begin
    state_next = state_reg;
    grant_next = grant_reg;
    latch      = 1'b0;
    capture    = 1'b0;
    timer_load = 1'b0;
    timer_dec  = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (dbg_wins) begin
          grant_next = PORT_DBG;
          latch      = 1'b1;
          state_next = SETUP;
        end else if (cpu_req) begin
          grant_next = PORT_CPU;
          latch      = 1'b1;
          state_next = SETUP;
        end
      end
      SETUP: begin
        timer_load = 1'b1;
        state_next = ACCESS;
      end
      ACCESS: begin
        timer_dec = 1'b1;
        if (timer_zero) begin
          capture    = !we_reg;
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_reg <= IDLE;
      grant_reg <= PORT_CPU;
      addr_reg  <= '0;
      we_reg    <= 1'b0;
      wdata_reg <= '0;
      rdata_reg <= '0;
    end else begin
      state_reg <= state_next;
      grant_reg <= grant_next;
      // Operands are frozen at grant so requester changes mid-transfer are ignored.
      if (latch) begin
        if (grant_next == PORT_DBG) begin
          addr_reg  <= dbg_addr;
          we_reg    <= dbg_we;
          wdata_reg <= dbg_wdata;
        end else begin
          addr_reg  <= cpu_addr;
          we_reg    <= cpu_we;
          wdata_reg <= cpu_wdata;
        end
      end
      if (capture) begin
        rdata_reg <= Data_in;
      end
    end
  end

  // A only moves on the IDLE->SETUP edge, so WE (low only in ACCESS) never overlaps an address change.
  assign CE        = (state_reg == IDLE);
  assign UB        = (state_reg == IDLE);
  assign LB        = (state_reg == IDLE);
  assign OE        = !(!we_reg && ((state_reg == SETUP) || (state_reg == ACCESS)));
  assign WE        = !(we_reg && (state_reg == ACCESS));
  assign drive_en  = we_reg && (state_reg != IDLE);
  assign Data_out  = wdata_reg;
  assign A         = addr_reg;
  assign rdata     = rdata_reg;
  assign cpu_ready = (state_reg == DONE) && (grant_reg == PORT_CPU);

endmodule

// File: tb/tb_slc3_mem_arbiter.sv
// Self-checking bench for slc3_mem_arbiter; adapts to SLC3_MEM_ARB_DBG_EN being defined or not.
module tb_slc3_mem_arbiter;

  localparam int AW     = 20;
  localparam int DW     = 16;
  localparam int WAITC  = 2;
  localparam int STARVE = 4;

  typedef struct {
    bit wr;
    int cyc;
    bit ce;
    bit oe;
    bit we;
    bit de;
    bit rdy;
  } vec_t;

  logic          Clk = 1'b0;
  logic          Reset = 1'b0;
  logic          cpu_req = 1'b0;
  logic          cpu_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_wdata = '0;
  logic          dbg_req = 1'b0;
  logic          dbg_we = 1'b0;
  logic [AW-1:0] dbg_addr = '0;
  logic [DW-1:0] dbg_wdata = '0;
  logic          cpu_ready, dbg_ready;
  logic [DW-1:0] rdata;
  logic [AW-1:0] A;
  logic          CE, UB, LB, OE, WE;
  logic [DW-1:0] Data_out;
  logic          drive_en;
  logic [DW-1:0] Data_in;
  logic          din_force = 1'b0;
  logic [DW-1:0] din_val = '0;

  logic          w1_cpu_ready;
  logic [DW-1:0] w1_rdata;
  logic [DW-1:0] Data_in1 = '0;
  logic          unused_w1_dbg_ready, unused_w1_CE, unused_w1_UB, unused_w1_LB;
  logic          unused_w1_OE, unused_w1_WE, unused_w1_drive_en;
  logic [AW-1:0] unused_w1_A;
  logic [DW-1:0] unused_w1_Data_out;

  logic [DW-1:0] sram    [16];
  logic [DW-1:0] ref_mem [16];

  int checks = 0;
  int failures = 0;
  bit cpu_done, dbg_done;

  always #5 Clk = ~Clk;

  slc3_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(WAITC), .STARVE_MAX(STARVE)) dut (
    .Clk(Clk), .Reset(Reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_ready(cpu_ready),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata), .dbg_ready(dbg_ready),
    .rdata(rdata), .A(A), .CE(CE), .UB(UB), .LB(LB), .OE(OE), .WE(WE),
    .Data_out(Data_out), .drive_en(drive_en), .Data_in(Data_in)
  );

  slc3_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(1), .STARVE_MAX(STARVE)) dut_w1 (
    .Clk(Clk), .Reset(Reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_ready(w1_cpu_ready),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata), .dbg_ready(unused_w1_dbg_ready),
    .rdata(w1_rdata), .A(unused_w1_A), .CE(unused_w1_CE), .UB(unused_w1_UB), .LB(unused_w1_LB),
    .OE(unused_w1_OE), .WE(unused_w1_WE), .Data_out(unused_w1_Data_out), .drive_en(unused_w1_drive_en),
    .Data_in(Data_in1)
  );

  function automatic logic [DW-1:0] init_word(input int i);
    return DW'(i * 257 + 16'h3000);
  endfunction

  // Simple SRAM: reads through A when addressed, writes on edges where WE is low.
  assign Data_in = din_force ? din_val : sram[A[3:0]];

  always @(posedge Clk) begin
    if (!Reset) begin
      for (int i = 0; i < 16; i++) sram[i] <= init_word(i);
    end else if (!CE && !WE && drive_en) begin
      sram[A[3:0]] <= Data_out;
    end
  end

  task automatic tick;
    @(posedge Clk);
    @(negedge Clk);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset;
    Reset = 1'b0;
    cpu_req = 1'b0;
    dbg_req = 1'b0;
    din_force = 1'b0;
    tick();
    tick();
    for (int i = 0; i < 16; i++) ref_mem[i] = init_word(i);
    Reset = 1'b1;
    tick();
  endtask

  // Issue one transfer on a port, wait for its ready, check against the reference memory.
  task automatic port_xfer(input bit is_dbg, input bit we, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wdata, input bit chk_lat);
    int n;
    bit got;
    if (is_dbg) begin
      dbg_we = we; dbg_addr = addr; dbg_wdata = wdata; dbg_req = 1'b1;
    end else begin
      cpu_we = we; cpu_addr = addr; cpu_wdata = wdata; cpu_req = 1'b1;
    end
    n = 0;
    got = 1'b0;
    while (!got && n < 80) begin
      tick();
      n++;
      got = is_dbg ? dbg_ready : cpu_ready;
    end
    chk(is_dbg ? "dbg_xfer_done" : "cpu_xfer_done", 32'(got), 32'd1);
    if (got) begin
      if (chk_lat) chk("latency", n, WAITC + 2);
      chk("A_at_done", 32'(A), 32'(addr));
      if (we) begin
        chk("Data_out_at_done", 32'(Data_out), 32'(wdata));
        ref_mem[addr[3:0]] = wdata;
      end else begin
        chk("rdata", 32'(rdata), 32'(ref_mem[addr[3:0]]));
      end
    end
    if (is_dbg) dbg_req = 1'b0;
    else cpu_req = 1'b0;
  endtask

  initial begin
    vec_t          tbl [12];
    logic [AW-1:0] exp_addr;
    int            rdy_cnt, n, lost;
    bit            got_c, got_d, exp_d;

    tbl[0]  = '{0, 0, 1, 1, 1, 0, 0};
    tbl[1]  = '{0, 1, 0, 0, 1, 0, 0};
    tbl[2]  = '{0, 2, 0, 0, 1, 0, 0};
    tbl[3]  = '{0, 3, 0, 0, 1, 0, 0};
    tbl[4]  = '{0, 4, 0, 1, 1, 0, 1};
    tbl[5]  = '{0, 5, 1, 1, 1, 0, 0};
    tbl[6]  = '{1, 0, 1, 1, 1, 0, 0};
    tbl[7]  = '{1, 1, 0, 1, 1, 1, 0};
    tbl[8]  = '{1, 2, 0, 1, 0, 1, 0};
    tbl[9]  = '{1, 3, 0, 1, 0, 1, 0};
    tbl[10] = '{1, 4, 0, 1, 1, 1, 1};
    tbl[11] = '{1, 5, 1, 1, 1, 0, 0};
    exp_addr = '0;

    do_reset();
    chk("rst_CE", 32'(CE), 1);
    chk("rst_OE", 32'(OE), 1);
    chk("rst_WE", 32'(WE), 1);
    chk("rst_UB_LB", 32'({UB, LB}), 32'h3);
    chk("rst_A", 32'(A), 0);
    chk("rst_Data_out", 32'(Data_out), 0);
    chk("rst_drive_en", 32'(drive_en), 0);
    chk("rst_ready", 32'({cpu_ready, dbg_ready}), 0);
    chk("rst_rdata", 32'(rdata), 0);

    // Directed read (0x00123 -> 0xBEEF) and write (0x00004 <- 0x1234), cycle by cycle.
    for (int i = 0; i < 12; i++) begin
      if (tbl[i].cyc == 0) begin
        cpu_we    = tbl[i].wr;
        cpu_addr  = tbl[i].wr ? 20'h00004 : 20'h00123;
        cpu_wdata = 16'h1234;
        din_force = !tbl[i].wr;
        din_val   = 16'hBEEF;
        exp_addr  = cpu_addr;
        cpu_req   = 1'b1;
      end else begin
        tick();
      end
      chk($sformatf("tbl%0d_CE", i), 32'(CE), 32'(tbl[i].ce));
      chk($sformatf("tbl%0d_UB", i), 32'(UB), 32'(tbl[i].ce));
      chk($sformatf("tbl%0d_LB", i), 32'(LB), 32'(tbl[i].ce));
      chk($sformatf("tbl%0d_OE", i), 32'(OE), 32'(tbl[i].oe));
      chk($sformatf("tbl%0d_WE", i), 32'(WE), 32'(tbl[i].we));
      chk($sformatf("tbl%0d_drive_en", i), 32'(drive_en), 32'(tbl[i].de));
      chk($sformatf("tbl%0d_cpu_ready", i), 32'(cpu_ready), 32'(tbl[i].rdy));
      if (tbl[i].cyc >= 1) chk($sformatf("tbl%0d_A", i), 32'(A), 32'(exp_addr));
      if (tbl[i].wr && tbl[i].cyc >= 1 && tbl[i].cyc <= 4)
        chk($sformatf("tbl%0d_Data_out", i), 32'(Data_out), 32'h1234);
      if (tbl[i].cyc == 4) begin
        if (!tbl[i].wr) chk("read_rdata_BEEF", 32'(rdata), 32'hBEEF);
        else ref_mem[4] = 16'h1234;
        cpu_req = 1'b0;
      end
      if (tbl[i].cyc == 5) begin
        din_force = 1'b0;
        if (tbl[i].wr) chk("write_keeps_rdata", 32'(rdata), 32'hBEEF);
      end
    end

    // Randomized CPU-only traffic against the reference memory.
    for (int t = 0; t < 24; t++) begin
      repeat ($urandom_range(1, 3)) tick();
      port_xfer(1'b0, 1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom), 1'b1);
    end

    // Reset during the ACCESS phase of a write.
    do_reset();
    cpu_we = 1'b1; cpu_addr = 20'h00009; cpu_wdata = 16'hCAFE; cpu_req = 1'b1;
    tick();
    tick();
    chk("midrst_pre_WE", 32'(WE), 0);
    Reset = 1'b0;
    cpu_req = 1'b0;
    tick();
    chk("midrst_WE", 32'(WE), 1);
    chk("midrst_CE", 32'(CE), 1);
    chk("midrst_drive_en", 32'(drive_en), 0);
    chk("midrst_ready", 32'(cpu_ready), 0);
    chk("midrst_A", 32'(A), 0);
    chk("midrst_Data_out", 32'(Data_out), 0);
    for (int i = 0; i < 16; i++) ref_mem[i] = init_word(i);
    Reset = 1'b1;
    rdy_cnt = 0;
    repeat (6) begin
      tick();
      if (cpu_ready) rdy_cnt++;
    end
    chk("midrst_no_ready", rdy_cnt, 0);
    port_xfer(1'b0, 1'b0, 20'h00009, 16'h0000, 1'b1);

    // WAIT_CYCLES=1 instance: held read completes at cycles 3 and 7.
    do_reset();
    Data_in1 = 16'hA5A5;
    cpu_we = 1'b0; cpu_addr = 20'h00005; cpu_req = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      tick();
      chk($sformatf("w1_ready_c%0d", c), 32'(w1_cpu_ready), 32'((c == 3) || (c == 7)));
      if (c == 3) begin
        chk("w1_rdata1", 32'(w1_rdata), 32'hA5A5);
        Data_in1 = 16'h5A5A;
      end
      if (c == 7) chk("w1_rdata2", 32'(w1_rdata), 32'h5A5A);
    end
    cpu_req = 1'b0;

`ifdef SLC3_MEM_ARB_DBG_EN
    // Both ports held: the debug port must win every (STARVE+1)th transfer.
    do_reset();
    cpu_we = 1'b0; cpu_addr = 20'h00001; dbg_we = 1'b0; dbg_addr = 20'h00002;
    cpu_req = 1'b1;
    dbg_req = 1'b1;
    lost = 0;
    for (int t = 0; t < 10; t++) begin
      n = 0;
      got_c = 1'b0;
      got_d = 1'b0;
      while (!(got_c || got_d) && n < 20) begin
        tick();
        n++;
        got_c = cpu_ready;
        got_d = dbg_ready;
      end
      exp_d = (lost == STARVE);
      chk($sformatf("grant%0d_dbg", t), 32'(got_d), 32'(exp_d));
      chk($sformatf("grant%0d_cpu", t), 32'(got_c), 32'(!exp_d));
      chk($sformatf("grant%0d_gap", t), n, (t == 0) ? WAITC + 2 : WAITC + 3);
      lost = exp_d ? 0 : lost + 1;
    end
    cpu_req = 1'b0;
    dbg_req = 1'b0;
    tick();

    // Debug-only write then randomized mixed traffic from both ports.
    do_reset();
    port_xfer(1'b1, 1'b1, 20'h0000B, 16'h7E57, 1'b1);
    cpu_done = 1'b0;
    dbg_done = 1'b0;
    fork
      begin
        for (int t = 0; t < 16; t++) begin
          repeat ($urandom_range(0, 2)) tick();
          port_xfer(1'b0, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), DW'($urandom), 1'b0);
        end
        cpu_done = 1'b1;
      end
      begin
        for (int t = 0; t < 16; t++) begin
          repeat ($urandom_range(0, 2)) tick();
          port_xfer(1'b1, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), DW'($urandom), 1'b0);
        end
        dbg_done = 1'b1;
      end
      begin
        logic [AW-1:0] prev_a;
        prev_a = A;
        while (!(cpu_done && dbg_done)) begin
          tick();
          if (!WE) chk("we_addr_stable", 32'(A), 32'(prev_a));
          if (cpu_ready || dbg_ready) chk("one_ready", 32'(cpu_ready && dbg_ready), 0);
          prev_a = A;
        end
      end
    join
`else
    // Debug port compiled out: its requests must be ignored.
    do_reset();
    dbg_we = 1'b1; dbg_addr = 20'h00007; dbg_wdata = 16'h1111; dbg_req = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      chk($sformatf("nodbg_CE_c%0d", c), 32'(CE), 1);
      chk($sformatf("nodbg_ready_c%0d", c), 32'(dbg_ready), 0);
    end
    dbg_req = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
